// File: rtl/avr_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : avr_alu_exec
// Purpose  : Multi-cycle execute unit for AVR arithmetic, logic and move
//            instructions. Owns the general-purpose register file and the
//            flag bits SREG[5:0] = {H,S,V,N,Z,C}.
//            Sequence: IDLE -> READ -> EXEC -> WRITE -> IDLE. done pulses
//            3 cycles after the accepting edge.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            start, op, rd, rr, imm - operation request and operands
//            busy, done         - handshake (busy through the done cycle)
//            result, sreg       - last result and flags, held until next done
//            dbg_addr, dbg_data - combinational register-file read port
// Revision : 1.0 - initial release
// ============================================================================
module avr_alu_exec #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rr,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [5:0]        sreg,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_EOR  = 4'd6;
  localparam logic [3:0] OP_CP   = 4'd7;
  localparam logic [3:0] OP_CPC  = 4'd8;
  localparam logic [3:0] OP_LDI  = 4'd9;
  localparam logic [3:0] OP_SUBI = 4'd11;
  localparam logic [3:0] OP_SBCI = 4'd12;
  localparam logic [3:0] OP_CPI  = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_DEC  = 4'd15;

  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_N = 2;
  localparam int F_V = 3;
  localparam int F_S = 4;
  localparam int F_H = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d, rr_q, rr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] res_h_q, res_h_d;
  logic [5:0]        flg_h_q, flg_h_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [5:0]        sreg_q, sreg_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Out-of-range addresses read as zero and never write.
  logic rd_ok, rr_ok, dbg_ok;
  assign rd_ok  = ({{(32-ADDR_W){1'b0}}, rd_q}     < 32'(NREGS));
  assign rr_ok  = ({{(32-ADDR_W){1'b0}}, rr_q}     < 32'(NREGS));
  assign dbg_ok = ({{(32-ADDR_W){1'b0}}, dbg_addr} < 32'(NREGS));

  logic use_imm, writes_rd;
  assign use_imm   = (op_q == OP_LDI) || (op_q == OP_SUBI) ||
                     (op_q == OP_SBCI) || (op_q == OP_CPI);
  assign writes_rd = (op_q != OP_CP) && (op_q != OP_CPC) && (op_q != OP_CPI);

  // Shared adder/subtractor; the 5-bit nibble paths give the bit-3 carry/borrow.
  logic              add_cin, sub_cin, z_chain;
  logic [DATA_W:0]   add_w, sub_w;
  logic [4:0]        add_lo, sub_lo;

  assign add_cin = (op_q == OP_ADC) & sreg_q[F_C];
  assign z_chain = (op_q == OP_SBC) || (op_q == OP_CPC) || (op_q == OP_SBCI);
  assign sub_cin = z_chain & sreg_q[F_C];

  assign add_w  = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, add_cin};
  assign sub_w  = {1'b0, a_q} - {1'b0, b_q} - {{DATA_W{1'b0}}, sub_cin};
  assign add_lo = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, add_cin};
  assign sub_lo = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, sub_cin};

  logic [DATA_W-1:0] alu_r;
  logic [5:0]        alu_f;
  logic              set_nzs, v_w;

  always_comb begin : p_alu
    alu_r   = a_q;
    alu_f   = sreg_q;
    set_nzs = 1'b1;
    v_w     = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        alu_r      = add_w[DATA_W-1:0];
        alu_f[F_C] = add_w[DATA_W];
        alu_f[F_H] = add_lo[4];
        v_w = (a_q[MSB] & b_q[MSB] & ~alu_r[MSB]) |
              (~a_q[MSB] & ~b_q[MSB] & alu_r[MSB]);
      end
      OP_SUB, OP_SBC, OP_CP, OP_CPC, OP_SUBI, OP_SBCI, OP_CPI: begin
        alu_r      = sub_w[DATA_W-1:0];
        alu_f[F_C] = sub_w[DATA_W];
        alu_f[F_H] = sub_lo[4];
        v_w = (a_q[MSB] & ~b_q[MSB] & ~alu_r[MSB]) |
              (~a_q[MSB] & b_q[MSB] & alu_r[MSB]);
      end
      OP_AND: alu_r = a_q & b_q;
      OP_OR:  alu_r = a_q | b_q;
      OP_EOR: alu_r = a_q ^ b_q;
      OP_INC: begin
        alu_r = a_q + {{(DATA_W-1){1'b0}}, 1'b1};
        v_w   = (alu_r == {1'b1, {(DATA_W-1){1'b0}}});
      end
      OP_DEC: begin
        alu_r = a_q - {{(DATA_W-1){1'b0}}, 1'b1};
        v_w   = (alu_r == {1'b0, {(DATA_W-1){1'b1}}});
      end
      default: begin  // LDI, MOV: plain move, flags untouched
        alu_r   = b_q;
        set_nzs = 1'b0;
      end
    endcase
    if (set_nzs) begin
      alu_f[F_V] = v_w;
      alu_f[F_N] = alu_r[MSB];
      alu_f[F_S] = alu_r[MSB] ^ v_w;
      // Carry-chained subtracts can only keep Z, never set it.
      alu_f[F_Z] = (alu_r == '0) & (~z_chain | sreg_q[F_Z]);
    end
  end

  always_comb begin : p_next
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rr_d     = rr_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    res_h_d  = res_h_q;
    flg_h_d  = flg_h_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    sreg_d   = sreg_q;
    regs_d   = regs_q;
    case (state_q)
      S_IDLE: begin
        // busy_q is still high during the done cycle; a start there is dropped.
        busy_d = 1'b0;
        if (start && !done_q) begin
          op_d    = op;
          rd_d    = rd;
          rr_d    = rr;
          imm_d   = imm;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = rd_ok ? regs_q[rd_q] : '0;
        b_d     = use_imm ? imm_q : (rr_ok ? regs_q[rr_q] : '0);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_h_d = alu_r;
        flg_h_d = alu_f;
        state_d = S_WRITE;
      end
      default: begin  // S_WRITE
        if (writes_rd && rd_ok) begin
          regs_d[rd_q] = res_h_q;
        end
        sreg_d   = flg_h_q;
        result_d = res_h_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : p_seq
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rr_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_h_q  <= '0;
      flg_h_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sreg_q   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rr_q     <= rr_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_h_q  <= res_h_d;
      flg_h_q  <= flg_h_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      sreg_q   <= sreg_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign sreg     = sreg_q;
  assign dbg_data = dbg_ok ? regs_q[dbg_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_avr_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_avr_alu_exec
// Purpose  : Self-checking bench for avr_alu_exec. An 8-bit instance is driven
//            with directed and random operations and compared against a
//            behavioural model built from signed/unsigned integer arithmetic.
//            A 16-bit instance with a short register file covers the wide
//            datapath and out-of-range register addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avr_alu_exec;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] op;
  logic [4:0] rd, rr, dbg_addr;
  logic [7:0] imm;
  logic       busy, done;
  logic [7:0] result, dbg_data;
  logic [5:0] sreg;

  logic        s_start;
  logic [3:0]  s_op;
  logic [3:0]  s_rd, s_rr, s_dbg_addr;
  logic [15:0] s_imm;
  logic        s_busy, s_done;
  logic [15:0] s_result, s_dbg_data;
  logic [5:0]  s_sreg;

  int n_checks = 0;
  int n_errors = 0;

  int       mregs [32];
  bit [5:0] msreg;

  always #5 clk = ~clk;

  avr_alu_exec #(.DATA_W(8), .NREGS(32), .ADDR_W(5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd), .rr(rr), .imm(imm),
    .busy(busy), .done(done), .result(result), .sreg(sreg),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  avr_alu_exec #(.DATA_W(16), .NREGS(12), .ADDR_W(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(s_start), .op(s_op), .rd(s_rd), .rr(s_rr),
    .imm(s_imm), .busy(s_busy), .done(s_done), .result(s_result),
    .sreg(s_sreg), .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sgn8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: flags {H,S,V,N,Z,C} derived from integer arithmetic.
  task automatic model(input int o, input int a, input int b, input bit [5:0] s,
                       output int r, output bit [5:0] ns, output bit wr);
    int  cin, full, sv;
    bit  v, setf, chain;
    ns    = s;
    wr    = !(o == 7 || o == 8 || o == 13);
    v     = 1'b0;
    setf  = 1'b1;
    chain = (o == 3 || o == 8 || o == 12);
    r     = 0;
    case (o)
      0, 1: begin
        cin   = (o == 1) ? int'(s[0]) : 0;
        full  = a + b + cin;
        r     = full & 255;
        ns[0] = full > 255;
        ns[5] = ((a & 15) + (b & 15) + cin) > 15;
        sv    = sgn8(a) + sgn8(b) + cin;
        v     = (sv > 127) || (sv < -128);
      end
      2, 3, 7, 8, 11, 12, 13: begin
        cin   = chain ? int'(s[0]) : 0;
        full  = a - b - cin;
        r     = full & 255;
        ns[0] = full < 0;
        ns[5] = ((a & 15) - (b & 15) - cin) < 0;
        sv    = sgn8(a) - sgn8(b) - cin;
        v     = (sv > 127) || (sv < -128);
      end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      14: begin r = (a + 1) & 255; v = (a == 127); end
      15: begin r = (a - 1) & 255; v = (a == 128); end
      default: begin r = b; setf = 1'b0; end
    endcase
    if (setf) begin
      ns[3] = v;
      ns[2] = r >= 128;
      ns[4] = (r >= 128) ^ v;
      ns[1] = (r == 0) && (!chain || s[1]);
    end
  endtask

  task automatic run_op(input int o, input int d, input int s, input int im, input bit hold);
    int a, b, r, lat;
    bit [5:0] ns;
    bit wr;
    a = mregs[d];
    b = (o == 9 || (o >= 11 && o <= 13)) ? im : mregs[s];
    model(o, a, b, msreg, r, ns, wr);
    op = o[3:0]; rd = d[4:0]; rr = s[4:0]; imm = im[7:0]; dbg_addr = d[4:0];
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("busy_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 3);
    check("result", {24'd0, result}, r);
    check("sreg", {26'd0, sreg}, {26'd0, ns});
    check("reg_rd", {24'd0, dbg_data}, wr ? r : a);
    check("busy_done", {31'd0, busy}, 32'd1);
    if (wr) mregs[d] = r;
    msreg = ns;
    // With hold set, start is still high across the edge ending the done cycle.
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after", {31'd0, busy}, 32'd0);
    check("done_after", {31'd0, done}, 32'd0);
    if (hold) begin
      @(posedge clk); #1;
      check("no_second_op", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic run16(input int o, input int d, input int s, input int im);
    int lat;
    s_op = o[3:0]; s_rd = d[3:0]; s_rr = s[3:0]; s_imm = im[15:0];
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 0;
    while (!s_done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency16", lat, 3);
    @(posedge clk); #1;
  endtask

  initial begin
    int o, d, s, im;
    bit seen_done;
    rst = 1'b1; start = 1'b0; op = '0; rd = '0; rr = '0; imm = '0; dbg_addr = '0;
    s_start = 1'b0; s_op = '0; s_rd = '0; s_rr = '0; s_imm = '0; s_dbg_addr = '0;
    foreach (mregs[i]) mregs[i] = 0;
    msreg = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_sreg", {26'd0, sreg}, 32'd0);
    for (int i = 0; i < 32; i += 7) begin
      dbg_addr = i[4:0]; #1;
      check("rst_reg", {24'd0, dbg_data}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Abort an ADD r1,r2 while in EXEC.
    run_op(9, 2, 0, 3, 1'b0);
    op = 4'd0; rd = 5'd1; rr = 5'd2; dbg_addr = 5'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sreg", {26'd0, sreg}, 32'd0);
    check("abort_r1", {24'd0, dbg_data}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    seen_done = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    foreach (mregs[i]) mregs[i] = 0;
    msreg = '0;

    // Directed sequences.
    run_op(9, 16, 0, 8'h7F, 1'b0);
    run_op(14, 16, 0, 0, 1'b0);
    check("inc_flags", {26'd0, sreg}, 32'b001100);
    run_op(9, 17, 0, 8'h0F, 1'b0);
    run_op(9, 18, 0, 8'h01, 1'b0);
    run_op(0, 17, 18, 0, 1'b0);
    check("add_h", {31'd0, sreg[5]}, 32'd1);
    run_op(9, 20, 0, 8'h00, 1'b0);
    run_op(9, 21, 0, 8'h01, 1'b0);
    run_op(11, 20, 0, 8'h01, 1'b0);
    run_op(12, 21, 0, 8'h00, 1'b0);
    check("sbci_z", {31'd0, sreg[1]}, 32'd0);
    run_op(9, 16, 0, 8'h55, 1'b0);
    run_op(7, 16, 16, 0, 1'b0);
    check("cp_z", {31'd0, sreg[1]}, 32'd1);
    run_op(6, 16, 16, 0, 1'b0);
    run_op(0, 17, 18, 0, 1'b1);

    // Random operations on a small register window to create dependencies.
    for (int k = 0; k < 80; k++) begin
      o  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) o = 9;
      d  = $urandom_range(0, 7);
      s  = $urandom_range(0, 7);
      im = $urandom_range(0, 255);
      run_op(o, d, s, im, ($urandom_range(0, 7) == 0));
    end

    // 16-bit instance: overflow into the sign bit, then out-of-range registers.
    run16(9, 1, 0, 16'h7FFF);
    run16(9, 2, 0, 16'h0001);
    run16(0, 1, 2, 0);
    check("w16_result", {16'd0, s_result}, 32'h8000);
    check("w16_sreg", {26'd0, s_sreg}, 32'b101100);
    s_dbg_addr = 4'd1; #1;
    check("w16_r1", {16'd0, s_dbg_data}, 32'h8000);
    run16(9, 13, 0, 16'h1234);
    s_dbg_addr = 4'd13; #1;
    check("w16_oor_write", {16'd0, s_dbg_data}, 32'd0);
    run16(0, 14, 1, 0);
    check("w16_oor_result", {16'd0, s_result}, 32'h8000);
    check("w16_oor_sreg", {26'd0, s_sreg}, 32'b010100);
    s_dbg_addr = 4'd14; #1;
    check("w16_oor_r14", {16'd0, s_dbg_data}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
